// File: rtl/decode_stage_p.sv
// ID stage of the five-stage MIPS pipeline: decode, register file read, immediate
// sign-extension, load-use stall detection and flush handling, registered into ID/EX.
module decode_stage_p #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter bit          RF_BYPASS  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_write_reg_location,
    input  logic [DATA_W-1:0]     mem_wb_write_data,
    input  logic [31:0]           if_id_instr,
    input  logic [DATA_W-1:0]     if_id_npc,
    input  logic                  if_id_valid,
    input  logic                  ex_flush,
    output logic                  id_stall,
    output logic                  id_ex_valid,
    output logic [1:0]            id_ex_wb,
    output logic [2:0]            id_ex_mem,
    output logic [3:0]            id_ex_execute,
    output logic [DATA_W-1:0]     id_ex_npc,
    output logic [DATA_W-1:0]     id_ex_readdat1,
    output logic [DATA_W-1:0]     id_ex_readdat2,
    output logic [DATA_W-1:0]     id_ex_sign_ext,
    output logic [REG_ADDR_W-1:0] id_ex_instr_bits_20_16,
    output logic [REG_ADDR_W-1:0] id_ex_instr_bits_15_11
);

    localparam int unsigned NREGS = 1 << REG_ADDR_W;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    logic [DATA_W-1:0]     r_regs [NREGS];

    logic                  r_valid;
    logic [1:0]            r_wb;
    logic [2:0]            r_mem;
    logic [3:0]            r_execute;
    logic [DATA_W-1:0]     r_npc;
    logic [DATA_W-1:0]     r_readdat1;
    logic [DATA_W-1:0]     r_readdat2;
    logic [DATA_W-1:0]     r_sign_ext;
    logic [REG_ADDR_W-1:0] r_rt;
    logic [REG_ADDR_W-1:0] r_rd;

    logic [5:0]            w_opcode;
    logic [REG_ADDR_W-1:0] w_rs;
    logic [REG_ADDR_W-1:0] w_rt;
    logic [REG_ADDR_W-1:0] w_rd;
    logic signed [15:0]    w_imm;
    logic [DATA_W-1:0]     w_sign_ext;
    logic [1:0]            w_wb;
    logic [2:0]            w_mem;
    logic [3:0]            w_execute;
    logic                  w_uses_rt;
    logic                  w_hazard;
    logic                  w_bubble;
    logic [DATA_W-1:0]     w_readdat1;
    logic [DATA_W-1:0]     w_readdat2;

    assign w_opcode   = if_id_instr[31:26];
    assign w_rs       = if_id_instr[21 +: REG_ADDR_W];
    assign w_rt       = if_id_instr[16 +: REG_ADDR_W];
    assign w_rd       = if_id_instr[11 +: REG_ADDR_W];
    assign w_imm      = if_id_instr[15:0];
    assign w_sign_ext = DATA_W'(w_imm);

    always_comb begin
        w_wb      = '0;
        w_mem     = '0;
        w_execute = '0;
        w_uses_rt = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                w_wb      = 2'b10;
                w_execute = 4'b1100;
                w_uses_rt = 1'b1;
            end
            OP_LW: begin
                w_wb      = 2'b11;
                w_mem     = 3'b010;
                w_execute = 4'b0001;
            end
            OP_SW: begin
                w_mem     = 3'b001;
                w_execute = 4'b0001;
                w_uses_rt = 1'b1;
            end
            OP_BEQ: begin
                w_mem     = 3'b100;
                w_execute = 4'b0010;
                w_uses_rt = 1'b1;
            end
            OP_ADDI: begin
                w_wb      = 2'b10;
                w_execute = 4'b0001;
            end
            default: ;
        endcase
    end

    // Register 0 is hard-wired; the bypass check comes before it so r0 never forwards.
    always_comb begin
        w_readdat1 = r_regs[w_rs];
        if (RF_BYPASS && wb_reg_write && (wb_write_reg_location == w_rs))
            w_readdat1 = mem_wb_write_data;
        if (w_rs == '0)
            w_readdat1 = '0;

        w_readdat2 = r_regs[w_rt];
        if (RF_BYPASS && wb_reg_write && (wb_write_reg_location == w_rt))
            w_readdat2 = mem_wb_write_data;
        if (w_rt == '0)
            w_readdat2 = '0;
    end

    assign w_hazard = if_id_valid && r_valid && r_mem[1] && (r_rt != '0) &&
                      ((r_rt == w_rs) || (w_uses_rt && (r_rt == w_rt)));
    // A flush redirects IF, so holding PC and IF/ID would be wrong.
    assign id_stall = w_hazard && !ex_flush;
    assign w_bubble = w_hazard || ex_flush || !if_id_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else if (wb_reg_write && (wb_write_reg_location != '0)) begin
            r_regs[wb_write_reg_location] <= mem_wb_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_wb       <= '0;
            r_mem      <= '0;
            r_execute  <= '0;
            r_npc      <= '0;
            r_readdat1 <= '0;
            r_readdat2 <= '0;
            r_sign_ext <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
        end else begin
            r_valid    <= !w_bubble;
            r_wb       <= w_bubble ? '0 : w_wb;
            r_mem      <= w_bubble ? '0 : w_mem;
            r_execute  <= w_bubble ? '0 : w_execute;
            r_npc      <= if_id_npc;
            r_readdat1 <= w_readdat1;
            r_readdat2 <= w_readdat2;
            r_sign_ext <= w_sign_ext;
            r_rt       <= w_rt;
            r_rd       <= w_rd;
        end
    end

    assign id_ex_valid            = r_valid;
    assign id_ex_wb               = r_wb;
    assign id_ex_mem              = r_mem;
    assign id_ex_execute          = r_execute;
    assign id_ex_npc              = r_npc;
    assign id_ex_readdat1         = r_readdat1;
    assign id_ex_readdat2         = r_readdat2;
    assign id_ex_sign_ext         = r_sign_ext;
    assign id_ex_instr_bits_20_16 = r_rt;
    assign id_ex_instr_bits_15_11 = r_rd;

endmodule

// File: tb/tb_decode_stage_p.sv
// Scoreboard bench for decode_stage_p: a bypassing 32-bit instance checked against a
// reference model, plus a 16-bit non-bypassing instance fed the same stimulus.
module tb_decode_stage_p;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wloc;
    logic [31:0] wdat;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        ivalid;
    logic        flush;

    logic        id_stall;
    logic        id_ex_valid;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_mem;
    logic [3:0]  id_ex_execute;
    logic [31:0] id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext;
    logic [4:0]  id_ex_rt, id_ex_rd;

    logic        d2_stall;
    logic        d2_valid;
    logic [1:0]  d2_wb;
    logic [2:0]  d2_mem;
    logic [3:0]  d2_execute;
    logic [15:0] d2_npc, d2_rd1, d2_rd2, d2_sext;
    logic [4:0]  d2_rt, d2_rd;

    always #5 clk = ~clk;

    decode_stage_p #(.DATA_W(32), .REG_ADDR_W(5), .RF_BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .wb_reg_write(we), .wb_write_reg_location(wloc),
        .mem_wb_write_data(wdat), .if_id_instr(instr), .if_id_npc(npc),
        .if_id_valid(ivalid), .ex_flush(flush), .id_stall(id_stall),
        .id_ex_valid(id_ex_valid), .id_ex_wb(id_ex_wb), .id_ex_mem(id_ex_mem),
        .id_ex_execute(id_ex_execute), .id_ex_npc(id_ex_npc),
        .id_ex_readdat1(id_ex_readdat1), .id_ex_readdat2(id_ex_readdat2),
        .id_ex_sign_ext(id_ex_sign_ext), .id_ex_instr_bits_20_16(id_ex_rt),
        .id_ex_instr_bits_15_11(id_ex_rd)
    );

    decode_stage_p #(.DATA_W(16), .REG_ADDR_W(5), .RF_BYPASS(1'b0)) dut16 (
        .clk(clk), .rst(rst), .wb_reg_write(we), .wb_write_reg_location(wloc),
        .mem_wb_write_data(wdat[15:0]), .if_id_instr(instr), .if_id_npc(npc[15:0]),
        .if_id_valid(ivalid), .ex_flush(flush), .id_stall(d2_stall),
        .id_ex_valid(d2_valid), .id_ex_wb(d2_wb), .id_ex_mem(d2_mem),
        .id_ex_execute(d2_execute), .id_ex_npc(d2_npc),
        .id_ex_readdat1(d2_rd1), .id_ex_readdat2(d2_rd2),
        .id_ex_sign_ext(d2_sext), .id_ex_instr_bits_20_16(d2_rt),
        .id_ex_instr_bits_15_11(d2_rd)
    );

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [3:0]  ex;
        logic [31:0] npc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_prev;
    logic [31:0] m_rf [32];
    logic        first_cycle = 1'b1;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    endtask

    // Control table straight from the opcode list: {wb, mem, execute}.
    function automatic logic [8:0] ctl(input logic [5:0] op);
        case (op)
            6'h00:   return 9'b10_000_1100;
            6'h23:   return 9'b11_010_0001;
            6'h2B:   return 9'b00_001_0001;
            6'h04:   return 9'b00_100_0010;
            6'h08:   return 9'b10_000_0001;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic [31:0] rd_model(input logic [4:0] r, input logic w,
                                             input logic [4:0] loc, input logic [31:0] d);
        if (r == 5'd0)
            return 32'd0;
        if (w && loc == r)
            return d;
        return m_rf[r];
    endfunction

    task automatic drive(input logic r, input logic w, input logic [4:0] loc,
                         input logic [31:0] dat, input logic [31:0] ins,
                         input logic [31:0] pc, input logic v, input logic fl);
        exp_t        e;
        exp_t        got;
        logic [4:0]  rs, rt;
        logic        uses_rt, stl, bub;
        rst = r; we = w; wloc = loc; wdat = dat;
        instr = ins; npc = pc; ivalid = v; flush = fl;
        rs = ins[25:21];
        rt = ins[20:16];
        uses_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) || (ins[31:26] == 6'h04);
        stl = !fl && v && m_prev.valid && m_prev.mem[1] && (m_prev.rt != 5'd0) &&
              ((m_prev.rt == rs) || (uses_rt && m_prev.rt == rt));
        bub = stl || fl || !v;
        #2;
        if (!first_cycle)
            chk("id_stall", {31'd0, id_stall}, {31'd0, stl});
        first_cycle = 1'b0;
        e = '0;
        if (r) begin
            e.rst = 1'b1;
        end else begin
            e.valid = !bub;
            {e.wb, e.mem, e.ex} = bub ? 9'd0 : ctl(ins[31:26]);
            e.npc  = pc;
            e.rd1  = rd_model(rs, w, loc, dat);
            e.rd2  = rd_model(rt, w, loc, dat);
            e.sext = {{16{ins[15]}}, ins[15:0]};
            e.rt   = rt;
            e.rd   = ins[15:11];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("valid", {31'd0, id_ex_valid}, {31'd0, got.valid});
        chk("wb", {30'd0, id_ex_wb}, {30'd0, got.wb});
        chk("mem", {29'd0, id_ex_mem}, {29'd0, got.mem});
        chk("execute", {28'd0, id_ex_execute}, {28'd0, got.ex});
        if (got.rst || got.valid) begin
            chk("npc", id_ex_npc, got.npc);
            chk("readdat1", id_ex_readdat1, got.rd1);
            chk("readdat2", id_ex_readdat2, got.rd2);
            chk("sign_ext", id_ex_sign_ext, got.sext);
            chk("rt", {27'd0, id_ex_rt}, {27'd0, got.rt});
            chk("rd", {27'd0, id_ex_rd}, {27'd0, got.rd});
        end
        if (r) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else if (w && loc != 5'd0) begin
            m_rf[loc] = dat;
        end
        m_prev = got;
    endtask

    initial begin
        logic [31:0] ops [6];
        logic [4:0]  wr [4];
        logic [31:0] ins;
        ops = '{32'h0000_0000, 32'h8C00_0000, 32'hAC00_0000, 32'h1000_0000,
                32'h2000_0000, 32'hFC00_0000};
        wr  = '{5'd3, 5'd5, 5'd6, 5'd7};
        m_prev = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;

        // Reset with a live instruction and a WB write that must be ignored.
        drive(1, 1, 5'd5, 32'hDEAD_BEEF, 32'h00A4_1020, 32'h55, 1, 0);
        chk("d16_reset_sext", {16'd0, d2_sext}, 32'h0);
        drive(0, 0, 5'd0, 32'h0, 32'h00A4_1020, 32'h1, 1, 0);
        chk("d16_rtype_sext", {16'd0, d2_sext}, 32'h1020);

        for (int i = 0; i < 4; i++)
            drive(0, 1, wr[i], $urandom, 32'h00A6_3820, 32'h100 + i, 1, 0);

        // Load-use: lw r2 then add reading r2, held through the stall.
        drive(0, 0, 5'd0, 32'h0, 32'h8C82_0002, 32'h10, 1, 0);
        drive(0, 0, 5'd0, 32'h0, 32'h0042_1020, 32'h14, 1, 0);
        drive(0, 0, 5'd0, 32'h0, 32'h0042_1020, 32'h14, 1, 0);

        // Same-cycle write/read of r2: forwarded in the bypassing instance only.
        drive(0, 1, 5'd2, 32'h64, 32'h0042_1020, 32'h18, 1, 0);
        chk("d16_nobypass_rd1", {16'd0, d2_rd1}, 32'h0);
        chk("d16_nobypass_rd2", {16'd0, d2_rd2}, 32'h0);
        drive(0, 0, 5'd0, 32'h0, 32'h0042_1020, 32'h1C, 1, 0);
        chk("d16_late_rd1", {16'd0, d2_rd1}, 32'h64);
        chk("d16_late_rd2", {16'd0, d2_rd2}, 32'h64);

        // Register 0 writes dropped, never forwarded; negative immediate.
        drive(0, 1, 5'd0, 32'h64, 32'h0000_1020, 32'h20, 1, 0);
        drive(0, 0, 5'd0, 32'h0, 32'h8C80_FFFE, 32'h24, 1, 0);
        chk("d16_sext_neg", {16'd0, d2_sext}, 32'h0000_FFFE);
        drive(0, 0, 5'd0, 32'h0, 32'h0000_1020, 32'h28, 1, 0);

        // Flush during a load-use hazard, then sw.
        drive(0, 0, 5'd0, 32'h0, 32'h8C82_0002, 32'h30, 1, 0);
        drive(0, 0, 5'd0, 32'h0, 32'h0042_1020, 32'h34, 1, 1);
        drive(0, 0, 5'd0, 32'h0, 32'hAC82_0002, 32'h38, 1, 0);

        // sw uses rt (stalls); addi does not (no stall).
        drive(0, 0, 5'd0, 32'h0, 32'h8C82_0002, 32'h40, 1, 0);
        drive(0, 0, 5'd0, 32'h0, 32'hAC62_0000, 32'h44, 1, 0);
        drive(0, 0, 5'd0, 32'h0, 32'hAC62_0000, 32'h44, 1, 0);
        drive(0, 0, 5'd0, 32'h0, 32'h8C82_0002, 32'h48, 1, 0);
        drive(0, 0, 5'd0, 32'h0, 32'h2062_0000, 32'h4C, 1, 0);
        drive(0, 0, 5'd0, 32'h0, 32'h1043_0003, 32'h50, 1, 0);
        drive(0, 0, 5'd0, 32'h0, 32'hFC00_0000, 32'h54, 1, 0);
        drive(0, 0, 5'd0, 32'h0, 32'h0042_1020, 32'h58, 0, 0);

        // Reset arriving while a stall is pending.
        drive(0, 0, 5'd0, 32'h0, 32'h8C82_0002, 32'h60, 1, 0);
        drive(1, 0, 5'd0, 32'h0, 32'h0042_1020, 32'h64, 1, 0);
        drive(0, 0, 5'd0, 32'h0, 32'h0042_1020, 32'h64, 1, 0);

        for (int i = 0; i < 80; i++) begin
            ins = ops[$urandom_range(0, 5)];
            ins[25:0] = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            drive(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, ins,
                  $urandom, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_stage_p.md
# decode_stage_p

Parametrised ID stage for the five-stage MIPS pipeline, placed between the IF/ID and ID/EX boundaries. It decodes the instruction, reads the register file and sign-extends the immediate. It registers everything into the ID/EX outputs. Beyond the fixed-width decode it adds four things: configurable data width, an optional write-through bypass on the register file, load-use hazard detection with stall, and a flush input from branch resolution.

## Interface
- DATA_W, 32, width of register data, NPC and sign-extended immediate (>=16)
- REG_ADDR_W, 5, register index width; file holds 2**REG_ADDR_W entries; instruction fields use low REG_ADDR_W bits of rs/rt/rd
- RF_BYPASS, 1, 1 = a same-cycle WB write to a read register is forwarded to the read data
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- wb_reg_write  in  1  WB write enable
- wb_write_reg_location  in  REG_ADDR_W  WB destination register
- mem_wb_write_data  in  DATA_W  WB write data
- if_id_instr  in  32  instruction
- if_id_npc  in  DATA_W  next PC
- if_id_valid  in  1  IF/ID holds a real instruction
- ex_flush  in  1  squash the instruction currently in ID
- id_stall  out  1  hold PC and IF/ID this cycle (combinational)
- id_ex_valid  out  1  ID/EX holds a real instruction
- id_ex_wb  out  2  {RegWrite, MemtoReg}
- id_ex_mem  out  3  {Branch, MemRead, MemWrite}
- id_ex_execute  out  4  {RegDst, ALUOp[1:0], ALUSrc}
- id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext  out  DATA_W each
- id_ex_instr_bits_20_16, id_ex_instr_bits_15_11  out  REG_ADDR_W each  rt, rd

## Operation
- Decode by opcode [31:26], listed as wb / mem / execute:
  - R-type 0x00: 10 / 000 / 1100
  - lw 0x23: 11 / 010 / 0001
  - sw 0x2B: 00 / 001 / 0001
  - beq 0x04: 00 / 100 / 0010
  - addi 0x08: 10 / 000 / 0001
  - Any other opcode: all controls 0, valid still propagates.
- Sign extension: instr[15] replicated into bits DATA_W-1:16.
- Register file:
  - Read ports rs=[25:21] and rt=[20:16] are combinational.
  - A write occurs at the clock edge when wb_reg_write is 1 and the location is nonzero.
  - Register 0 always reads 0; writes to register 0 are dropped.
- Bypass: with RF_BYPASS=1, a read of register r (r≠0) returns mem_wb_write_data when wb_reg_write is 1 and location equals r in the same cycle.
- Load-use hazard: id_stall = if_id_valid & id_ex_valid & id_ex_mem[1] & (id_ex rt≠0) & (id_ex rt == rs, or id_ex rt == rt when the ID opcode is R-type, sw or beq).
- Bubble: on stall, ex_flush or if_id_valid=0, ID/EX loads valid=0 with wb/mem/execute=0. Data fields still load from the current inputs and are don't-care.
- Flush priority: ex_flush overrides the hazard and forces id_stall=0, because IF is being redirected.
- Register writes continue during stall and flush.

## Timing
- Latency: one cycle, ID inputs to ID/EX outputs.
- Reset:
  - At a clock edge with rst=1, all ID/EX outputs clear to 0, including valid.
  - All register file entries clear to 0.
  - A WB write in the same cycle is ignored.
  - id_stall is 0 while id_ex_valid is 0.
- Stall lasts exactly one cycle per load-use pair. The bubble clears id_ex_mem[1], so the hazard releases on the following cycle when IF/ID is held.
- rst asserted mid-stall: the next edge clears state and no stall follows.
- Without bypass (RF_BYPASS=0), a same-cycle write/read returns the old value; the new value is visible from the next cycle.

## Test plan
- Reset: rst=1 for one edge with arbitrary inputs -> all outputs 0; readdat of any register reads 0 afterwards.
- R-type: instr 0x00a41020, npc 0x1, valid=1 -> next edge: wb=10, mem=000, execute=1100, rt=4, rd=2, sign_ext=0x00001020, npc=0x1, valid=1.
- Load-use:
  - Stimulus: lw 0x8c820002 then add 0x00421020 held while id_stall=1.
  - Required: id_stall=1 for one cycle, followed by a bubble (valid=0, controls 0); add then issues with wb=10.
- Bypass/write:
  - Stimulus: wb_reg_write=1, location 2, data 0x64, with instr 0x00421020.
  - Required with RF_BYPASS=1: readdat1=readdat2=0x64 at the next edge.
  - Required with RF_BYPASS=0: old value 0 at that edge, 0x64 one cycle later.
- Register 0 and sign extension: write 0x64 to register 0, then read 0x8c80fffe -> readdat1=0 and sign_ext=0xfffffffe; with DATA_W=16, sign_ext=0xfffe.
- Flush priority: ex_flush=1 during a load-use hazard -> id_stall=0, bubble loaded; sw 0xac820002 issued next -> mem=001, execute=0001.
